// File: rtl/tamagotchi_pkg.sv
// Shared constants for the tamagotchi input stage: button channel indices,
// the system clock rate and the default debounce/hold cycle counts.
package tamagotchi_pkg;

  localparam int BTN_SALUD = 0;
  localparam int BTN_ALI   = 1;
  localparam int BTN_RESET = 2;
  localparam int BTN_TEST  = 3;

  localparam int CLK_HZ        = 50_000_000;
  localparam int DEBOUNCE_20MS = CLK_HZ / 50;
  localparam int HOLD_5S       = CLK_HZ * 5;

  // Counter width able to hold values 0..limit-1, never narrower than 1 bit.
  function automatic int cntWidth(input int limit);
    int w;
    w = $clog2(limit);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchronizer, polarity normalization,
// counter debounce, press pulse and saturating long-press detector.
module btn_channel
  import tamagotchi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int HOLD_CYCLES     = HOLD_5S,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic long_o
);

  localparam int CW = cntWidth(DEBOUNCE_CYCLES);
  localparam int HW = cntWidth(HOLD_CYCLES + 1);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic          IDLE_RAW  = ACTIVE_LOW;

  logic          sync1_q, sync2_q;
  logic          norm;
  logic [CW-1:0] debCnt_q, debCnt_d;
  logic [HW-1:0] holdCnt_q, holdCnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          long_q, long_d;

  // Sync flops reset to the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign norm = sync2_q ^ IDLE_RAW;

  always_comb begin
    debCnt_d  = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    holdCnt_d = holdCnt_q;
    long_d    = 1'b0;

    if (norm != level_q) begin
      if (debCnt_q == DEB_LAST) begin
        level_d = norm;
        press_d = norm;
      end else begin
        debCnt_d = debCnt_q + CW'(1);
      end
    end

    // Saturation at HOLD_MAX is what keeps long-press from repeating.
    if (!level_q) begin
      holdCnt_d = '0;
    end else if (holdCnt_q != HOLD_MAX) begin
      holdCnt_d = holdCnt_q + HW'(1);
      long_d    = (holdCnt_q == HOLD_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debCnt_q  <= '0;
      holdCnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      debCnt_q  <= debCnt_d;
      holdCnt_q <= holdCnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      long_q    <= long_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign long_o  = long_q;

endmodule

// File: rtl/btn_conditioner.sv
// Input stage for the tamagotchi FSM: N_BTN independent button channels,
// each producing a debounced level, a press pulse and a long-press pulse.
module btn_conditioner
  import tamagotchi_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int HOLD_CYCLES     = HOLD_5S,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] long_press
);

  // Channels share nothing, so simultaneous presses pulse together.
  for (genvar g = 0; g < N_BTN; g++) begin : gen_channel
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_channel (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (btn_raw[g]),
      .level_o(btn_level[g]),
      .press_o(btn_press[g]),
      .long_o (long_press[g])
    );
  end

endmodule
